// File: rtl/if_id_stage_reg_if.sv
// IF/ID stage bundle: stall/flush control, fetch-side inputs, decode-side
// outputs and debug/perf observation signals. clk/rst stay outside.
//
// Valid semantics: a word is transferred when its valid bit is high on a
// rising clock edge. if_valid marks a real fetch this cycle; there is no
// ready back to fetch. Back-pressure comes only from the stall vector, and
// a word arriving while the skid entry is occupied is dropped and flagged
// in skid_ovf. id_valid marks a real instruction in the id_* registers.
interface if_id_stage_reg_if #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int STALL_W = 6,
  parameter int CNT_W   = 16
);
  logic [STALL_W-1:0] stall;
  logic               flush;
  logic [ADDR_W-1:0]  if_pc;
  logic [INST_W-1:0]  if_inst;
  logic               if_valid;
  logic               if_excp;
  logic [ADDR_W-1:0]  id_pc;
  logic [INST_W-1:0]  id_inst;
  logic               id_valid;
  logic               id_excp;
  logic [CNT_W-1:0]   bubble_cnt;
  logic               skid_ovf;
  logic               dbg_skid_full;

  // Controller/fetch side: drives control and fetch word, observes decode side
  modport master (
    output stall, flush, if_pc, if_inst, if_valid, if_excp,
    input  id_pc, id_inst, id_valid, id_excp, bubble_cnt, skid_ovf, dbg_skid_full
  );

  // Pipeline register side
  modport slave (
    input  stall, flush, if_pc, if_inst, if_valid, if_excp,
    output id_pc, id_inst, id_valid, id_excp, bubble_cnt, skid_ovf, dbg_skid_full
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF->ID pipeline register for the openMIPS core.
// Handles stall (hold vs. bubble), flush, fetch valid/exception tagging,
// a one-entry skid buffer for the word in flight from the synchronous ROM,
// and a saturating bubble counter with sticky skid-overflow flag.
// All outputs come straight from flops; no combinational if_* -> id_* path.
module if_id_stage_reg #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                STALL_W  = 6,
  parameter int                STAGE    = 1,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int                CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  if_id_stage_reg_if.slave bus
);

  // Skid buffer occupancy is the only piece of control state
  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

  // Per-cycle operating mode decoded from flush and the two stall bits
  typedef enum logic [1:0] {
    MODE_FLUSH   = 2'd0,
    MODE_ADVANCE = 2'd1,
    MODE_BUBBLE  = 2'd2,
    MODE_HOLD    = 2'd3
  } mode_t;

  skid_state_t skid_state, skid_state_nx;
  mode_t       mode;

  logic               stall_if, stall_id;
  logic               stall_unused;

  logic [ADDR_W-1:0]  id_pc_q,    id_pc_nx;
  logic [INST_W-1:0]  id_inst_q,  id_inst_nx;
  logic               id_valid_q, id_valid_nx;
  logic               id_excp_q,  id_excp_nx;

  logic [ADDR_W-1:0]  skid_pc_q,   skid_pc_nx;
  logic [INST_W-1:0]  skid_inst_q, skid_inst_nx;
  logic               skid_excp_q, skid_excp_nx;

  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic               ovf_q, ovf_nx;

  assign stall_if = bus.stall[STAGE];
  assign stall_id = bus.stall[STAGE+1];
  // Other stages' stall bits are not ours to act on
  assign stall_unused = ^bus.stall;

  // Mode decode; stall_if=0 with stall_id=1 is illegal from ctrl and advances
  always_comb begin
    mode = MODE_ADVANCE;
    if (bus.flush) begin
      mode = MODE_FLUSH;
    end else if (!stall_if) begin
      mode = MODE_ADVANCE;
    end else if (!stall_id) begin
      mode = MODE_BUBBLE;
    end else begin
      mode = MODE_HOLD;
    end
  end

  // Skid occupancy state register
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_state <= SKID_EMPTY;
    end else begin
      skid_state <= skid_state_nx;
    end
  end

  // Next-state and next-register values for decode outputs, skid and counters
  always_comb begin
    skid_state_nx = skid_state;
    id_pc_nx      = id_pc_q;
    id_inst_nx    = id_inst_q;
    id_valid_nx   = id_valid_q;
    id_excp_nx    = id_excp_q;
    skid_pc_nx    = skid_pc_q;
    skid_inst_nx  = skid_inst_q;
    skid_excp_nx  = skid_excp_q;
    cnt_nx        = cnt_q;
    ovf_nx        = ovf_q;

    case (mode)
      MODE_FLUSH: begin
        // Kill everything, including the incoming word; not a stall bubble
        id_pc_nx      = '0;
        id_inst_nx    = NOP_INST;
        id_valid_nx   = 1'b0;
        id_excp_nx    = 1'b0;
        skid_state_nx = SKID_EMPTY;
      end
      MODE_ADVANCE: begin
        if (skid_state == SKID_FULL) begin
          // Older parked word leaves first; the new word takes its place
          id_pc_nx    = skid_pc_q;
          id_inst_nx  = skid_inst_q;
          id_valid_nx = 1'b1;
          id_excp_nx  = skid_excp_q;
          if (bus.if_valid) begin
            skid_pc_nx   = bus.if_pc;
            skid_inst_nx = bus.if_inst;
            skid_excp_nx = bus.if_excp;
          end else begin
            skid_state_nx = SKID_EMPTY;
          end
        end else if (bus.if_valid) begin
          id_pc_nx    = bus.if_pc;
          id_inst_nx  = bus.if_inst;
          id_valid_nx = 1'b1;
          id_excp_nx  = bus.if_excp;
        end else begin
          // No fetch this cycle: load an uncounted bubble
          id_pc_nx    = '0;
          id_inst_nx  = NOP_INST;
          id_valid_nx = 1'b0;
          id_excp_nx  = 1'b0;
        end
      end
      MODE_BUBBLE: begin
        id_pc_nx    = '0;
        id_inst_nx  = NOP_INST;
        id_valid_nx = 1'b0;
        id_excp_nx  = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: begin
        // MODE_HOLD: decode registers keep their contents
      end
    endcase

    // While fetch is stalled, the word already in flight from the ROM parks
    if ((mode == MODE_BUBBLE || mode == MODE_HOLD) && bus.if_valid) begin
      if (skid_state == SKID_EMPTY) begin
        skid_pc_nx    = bus.if_pc;
        skid_inst_nx  = bus.if_inst;
        skid_excp_nx  = bus.if_excp;
        skid_state_nx = SKID_FULL;
      end else begin
        ovf_nx = 1'b1;
      end
    end
  end

  // Datapath registers: decode outputs, skid payload, bubble counter, overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q     <= '0;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      id_excp_q   <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= NOP_INST;
      skid_excp_q <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      id_pc_q     <= id_pc_nx;
      id_inst_q   <= id_inst_nx;
      id_valid_q  <= id_valid_nx;
      id_excp_q   <= id_excp_nx;
      skid_pc_q   <= skid_pc_nx;
      skid_inst_q <= skid_inst_nx;
      skid_excp_q <= skid_excp_nx;
      cnt_q       <= cnt_nx;
      ovf_q       <= ovf_nx;
    end
  end

  assign bus.id_pc         = id_pc_q;
  assign bus.id_inst       = id_inst_q;
  assign bus.id_valid      = id_valid_q;
  assign bus.id_excp       = id_excp_q;
  assign bus.bubble_cnt    = cnt_q;
  assign bus.skid_ovf      = ovf_q;
  assign bus.dbg_skid_full = (skid_state == SKID_FULL);

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed bench for if_id_stage_reg: reset, streaming, hold with skid,
// bubble, flush, skid overflow, illegal stall combination, and a narrow
// counter instance for saturation and exception tagging.
module tb_if_id_stage_reg;

  localparam logic [31:0] NOP = 32'h0BAD_0000;

  logic clk;
  logic rst;

  int checks;
  int errors;

  if_id_stage_reg_if #(.ADDR_W(32), .INST_W(32), .STALL_W(6), .CNT_W(16)) bus  ();
  if_id_stage_reg_if #(.ADDR_W(32), .INST_W(32), .STALL_W(6), .CNT_W(2))  bus2 ();

  if_id_stage_reg #(
    .ADDR_W(32), .INST_W(32), .STALL_W(6), .STAGE(1), .NOP_INST(NOP), .CNT_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_id_stage_reg #(
    .ADDR_W(32), .INST_W(32), .STALL_W(6), .STAGE(1), .NOP_INST(NOP), .CNT_W(2)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA500_0000 | pc;
  endfunction

  // Advance one edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                       input logic [31:0] pc, input logic ex);
    bus.stall    = st;
    bus.flush    = fl;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_inst  = inst_of(pc);
    bus.if_excp  = ex;
  endtask

  task automatic drive2(input logic [5:0] st, input logic v,
                        input logic [31:0] pc, input logic ex);
    bus2.stall    = st;
    bus2.flush    = 1'b0;
    bus2.if_valid = v;
    bus2.if_pc    = pc;
    bus2.if_inst  = inst_of(pc);
    bus2.if_excp  = ex;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all four decode fields; a bubble expects pc 0 and NOP
  task automatic chk_id(input string tag, input logic v, input logic [31:0] pc, input logic ex);
    chk({tag, ".valid"}, {63'd0, bus.id_valid}, {63'd0, v});
    chk({tag, ".pc"},    {32'd0, bus.id_pc},    {32'd0, v ? pc : 32'd0});
    chk({tag, ".inst"},  {32'd0, bus.id_inst},  {32'd0, v ? inst_of(pc) : NOP});
    chk({tag, ".excp"},  {63'd0, bus.id_excp},  {63'd0, v ? ex : 1'b0});
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset held for two cycles
    rst = 1'b1;
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    drive2(6'b000000, 1'b0, 32'h0, 1'b0);
    step();
    step();
    chk_id("reset", 1'b0, 32'h0, 1'b0);
    chk("reset.cnt",  {48'd0, bus.bubble_cnt}, 64'd0);
    chk("reset.ovf",  {63'd0, bus.skid_ovf},   64'd0);
    chk("reset.skid", {63'd0, bus.dbg_skid_full}, 64'd0);
    chk("reset.cnt2", {62'd0, bus2.bubble_cnt}, 64'd0);
    rst = 1'b0;

    // Streaming 0x0, 0x4, 0x8 with no stall: one cycle latency
    drive(6'b000000, 1'b0, 1'b1, 32'h0, 1'b0); step(); chk_id("stream0", 1'b1, 32'h0, 1'b0);
    drive(6'b000000, 1'b0, 1'b1, 32'h4, 1'b0); step(); chk_id("stream4", 1'b1, 32'h4, 1'b0);
    drive(6'b000000, 1'b0, 1'b1, 32'h8, 1'b0); step(); chk_id("stream8", 1'b1, 32'h8, 1'b0);

    // Hold two cycles with 0x10 in flight: outputs frozen, 0x10 parked
    drive(6'b000110, 1'b0, 1'b1, 32'h10, 1'b0); step(); chk_id("hold1", 1'b1, 32'h8, 1'b0);
    drive(6'b000110, 1'b0, 1'b0, 32'h0, 1'b0);  step(); chk_id("hold2", 1'b1, 32'h8, 1'b0);
    chk("hold.skid", {63'd0, bus.dbg_skid_full}, 64'd1);
    chk("hold.cnt",  {48'd0, bus.bubble_cnt}, 64'd0);
    // Release: parked 0x10 first, then 0x14 which had to wait in the skid
    drive(6'b000000, 1'b0, 1'b1, 32'h14, 1'b0); step(); chk_id("rel10", 1'b1, 32'h10, 1'b0);
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);  step(); chk_id("rel14", 1'b1, 32'h14, 1'b0);
    chk("rel.skid", {63'd0, bus.dbg_skid_full}, 64'd0);

    // One bubble cycle with 0x18 in flight, then resume in order
    drive(6'b000010, 1'b0, 1'b1, 32'h18, 1'b0); step(); chk_id("bubble", 1'b0, 32'h0, 1'b0);
    chk("bubble.cnt", {48'd0, bus.bubble_cnt}, 64'd1);
    drive(6'b000000, 1'b0, 1'b1, 32'h1C, 1'b0); step(); chk_id("resume18", 1'b1, 32'h18, 1'b0);
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);  step(); chk_id("resume1c", 1'b1, 32'h1C, 1'b0);
    chk("resume.cnt", {48'd0, bus.bubble_cnt}, 64'd1);

    // Flush while holding with a full skid
    drive(6'b000110, 1'b0, 1'b1, 32'h20, 1'b0); step(); chk_id("prefl", 1'b1, 32'h1C, 1'b0);
    chk("prefl.skid", {63'd0, bus.dbg_skid_full}, 64'd1);
    drive(6'b000110, 1'b1, 1'b1, 32'h24, 1'b0); step(); chk_id("flush", 1'b0, 32'h0, 1'b0);
    chk("flush.skid", {63'd0, bus.dbg_skid_full}, 64'd0);
    chk("flush.cnt",  {48'd0, bus.bubble_cnt}, 64'd1);
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);  step(); chk_id("postfl", 1'b0, 32'h0, 1'b0);
    chk("postfl.cnt", {48'd0, bus.bubble_cnt}, 64'd1);

    // Hold three cycles with a fetch each cycle: first parked, rest dropped
    drive(6'b000110, 1'b0, 1'b1, 32'h30, 1'b0); step();
    chk("ovf.c1", {63'd0, bus.skid_ovf}, 64'd0);
    drive(6'b000110, 1'b0, 1'b1, 32'h34, 1'b0); step();
    chk("ovf.c2", {63'd0, bus.skid_ovf}, 64'd1);
    drive(6'b000110, 1'b0, 1'b1, 32'h38, 1'b0); step();
    chk_id("ovf.hold", 1'b0, 32'h0, 1'b0);
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);  step(); chk_id("ovf.out30", 1'b1, 32'h30, 1'b0);
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);  step(); chk_id("ovf.empty", 1'b0, 32'h0, 1'b0);
    chk("ovf.sticky", {63'd0, bus.skid_ovf}, 64'd1);

    // Illegal stall pattern (decode stalled, fetch not) advances
    drive(6'b000100, 1'b0, 1'b1, 32'h40, 1'b1); step(); chk_id("illegal", 1'b1, 32'h40, 1'b1);
    chk("illegal.cnt", {48'd0, bus.bubble_cnt}, 64'd1);

    // Only reset clears the overflow flag and counter
    rst = 1'b1;
    drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    chk("rst2.ovf", {63'd0, bus.skid_ovf},   64'd0);
    chk("rst2.cnt", {48'd0, bus.bubble_cnt}, 64'd0);
    chk_id("rst2", 1'b0, 32'h0, 1'b0);

    // Narrow counter saturates at 3
    drive2(6'b000010, 1'b0, 32'h0, 1'b0); step(); chk("sat1", {62'd0, bus2.bubble_cnt}, 64'd1);
    chk("sat1.valid", {63'd0, bus2.id_valid}, 64'd0);
    drive2(6'b000010, 1'b0, 32'h0, 1'b0); step(); chk("sat2", {62'd0, bus2.bubble_cnt}, 64'd2);
    drive2(6'b000010, 1'b0, 32'h0, 1'b0); step(); chk("sat3", {62'd0, bus2.bubble_cnt}, 64'd3);
    drive2(6'b000010, 1'b0, 32'h0, 1'b0); step(); chk("sat4", {62'd0, bus2.bubble_cnt}, 64'd3);
    drive2(6'b000010, 1'b0, 32'h0, 1'b0); step(); chk("sat5", {62'd0, bus2.bubble_cnt}, 64'd3);

    // Fetch exception travels with its word
    drive2(6'b000000, 1'b1, 32'h20, 1'b1); step();
    chk("excp.valid", {63'd0, bus2.id_valid}, 64'd1);
    chk("excp.pc",    {32'd0, bus2.id_pc},    64'h20);
    chk("excp.inst",  {32'd0, bus2.id_inst},  {32'd0, inst_of(32'h20)});
    chk("excp.flag",  {63'd0, bus2.id_excp},  64'd1);
    chk("excp.cnt",   {62'd0, bus2.bubble_cnt}, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
